// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer.
package count_seq_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_e;

endpackage

// File: rtl/sync_load_counter.sv
// Up-counter with synchronous reset, synchronous load and count enable.
module sync_load_counter
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Load beats enable; increment wraps modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Multi-pass lo..hi count sequencer with pause, abort and a done pulse.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [WIDTH-1:0] lo_val,
  input  logic [WIDTH-1:0] hi_val,
  input  logic [WIDTH-1:0] passes,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] pass_cnt,
  output logic             busy,
  output logic             done
);

  localparam int unsigned EW = WIDTH + 1;

  state_e           state;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] passes_reg;
  logic [WIDTH-1:0] passes_eff;
  logic             at_hi;
  logic             more_passes;
  logic             run_step;
  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_load_val;

  // Terminal and pass comparisons; a pass count of zero behaves as one.
  always_comb begin
    passes_eff  = (passes_reg == '0) ? WIDTH'(1) : passes_reg;
    at_hi       = (count == hi_reg);
    more_passes = (EW'(pass_cnt) + EW'(1)) < EW'(passes_eff);
    run_step    = (state == S_RUN) && !pause;
  end

  // Counter control: abort clears, LOAD and pass wrap reload lo, RUN increments.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = lo_reg;
    if (abort) begin
      cnt_load     = 1'b1;
      cnt_load_val = '0;
    end else if (state == S_LOAD) begin
      cnt_load = 1'b1;
    end else if (run_step) begin
      if (!at_hi) begin
        cnt_en = 1'b1;
      end else if (more_passes) begin
        cnt_load = 1'b1;
      end
    end
  end

  sync_load_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .q        (count)
  );

  // Sequencer FSM; busy and done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pass_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      passes_reg <= '0;
    end else if (abort) begin
      state    <= S_IDLE;
      pass_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lo_reg     <= lo_val;
            hi_reg     <= hi_val;
            passes_reg <= passes;
            state      <= S_LOAD;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          pass_cnt <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state <= S_PAUSED;
          end else if (at_hi) begin
            if (more_passes) begin
              pass_cnt <= pass_cnt + WIDTH'(1);
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state <= S_RUN;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-005 abort  input  1  terminate any sequence; highest priority after reset.
REQ-006 pause  input  1  level; freezes counting while high during RUN.
REQ-007 lo_val  input  WIDTH  first count value of each pass.
REQ-008 hi_val  input  WIDTH  terminal count value of each pass.
REQ-009 passes  input  WIDTH  number of passes; 0 SHALL be treated as 1.
REQ-010 count  output  WIDTH  current counter value.
REQ-011 pass_cnt  output  WIDTH  index of current pass, 0-based.
REQ-012 busy  output  1  high in LOAD, RUN, PAUSED.
REQ-013 done  output  1  one-cycle pulse on sequence completion.

Function
REQ-014 States SHALL be IDLE, LOAD, RUN, PAUSED, DONE.
REQ-015 IDLE, start=1: capture lo_val/hi_val/passes into config registers; next state LOAD; count unchanged.
REQ-016 Config inputs SHALL be ignored outside the IDLE capture edge; start outside IDLE SHALL be ignored.
REQ-017 LOAD: count <= lo_reg, pass_cnt <= 0, next state RUN (first RUN cycle shows count=lo).
REQ-018 RUN, pause=0, count!=hi_reg: count <= count+1, modulo 2^WIDTH (lo>hi wraps through 0 up to hi).
REQ-019 RUN, pause=0, count==hi_reg, pass_cnt+1 < passes_eff: count <= lo_reg, pass_cnt++.
REQ-020 RUN, pause=0, count==hi_reg, last pass: next state DONE; count holds hi.
REQ-021 RUN, pause=1: next state PAUSED; count and pass_cnt hold that edge.
REQ-022 PAUSED: count holds; pause=0 returns to RUN; counting resumes the edge after return.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE; count holds hi, pass_cnt holds final index.
REQ-024 lo==hi: each pass lasts one RUN cycle.
REQ-025 abort=1 in any state: next state IDLE, count <= 0, pass_cnt <= 0, no done pulse.
REQ-026 abort and start same cycle in IDLE: abort wins; stays IDLE.
REQ-027 Outputs SHALL be registered; no combinational path input to output.

Reset
REQ-028 reset=1 at rising edge: state IDLE, count 0, pass_cnt 0, busy 0, done 0, config registers 0.
REQ-029 Reset SHALL override abort, start, pause, including mid-RUN and in DONE.

Structure
REQ-030 Shared package count_seq_pkg SHALL hold the state enumeration and WIDTH default.
REQ-031 Counter datapath SHALL be sub-module sync_load_counter (ports clk, reset, load, load_val, en, q).
REQ-032 FSM and terminal/pass comparisons SHALL reside in count_sequencer.

Verification
REQ-033 reset then start with lo=2, hi=5, passes=1 -> count 2,3,4,5, done pulse 1 cycle after 5 observed, busy low next cycle.
REQ-034 lo=14, hi=1, passes=2 -> count 14,15,0,1,14,15,0,1; pass_cnt 0 then 1; single done.
REQ-035 lo=0, hi=9, pause high 3 cycles at count=4 -> count holds 4 for 4 cycles (PAUSED + exit), then 5..9.
REQ-036 abort asserted at count=3 pass 0 -> next cycle count 0, busy 0, no done; later start works normally.
REQ-037 passes=0, lo=hi=7 -> one RUN cycle at 7, then done; start during RUN ignored, config change mid-run has no effect.
REQ-038 reset asserted mid-PAUSED -> all outputs 0 next cycle, state IDLE.
